// File: rtl/err_accumulator.sv
// -----------------------------------------------------------------------------
// err_accumulator
//
// Purpose:
//   Measures the quantisation error of the reduced-precision DSP path against
//   the full-precision reference path. After a start request the block waits
//   SKIP cycles for the DSP pipelines to settle. It then accumulates the
//   squared difference of 2^LOG2_SAMPLES sample pairs and reports the mean
//   squared error (truncating divide) as data_out.
//
// Optional feature (macro ERR_ACCUMULATOR_MAX_ERR_EN):
//   When defined, an extra output max_err reports the largest |data_in -
//   data_ref| seen in the current measurement window.
//
// Ports:
//   clk        in   1          system clock
//   rst        in   1          asynchronous active-high reset
//   start      in   1          single-cycle request to begin a measurement
//   data_in    in   DATA_W     reduced-precision DSP output, signed
//   data_ref   in   DATA_W     full-precision reference output, signed
//   data_out   out  ACC_W      mean of squared differences
//   data_valid out  1          result valid (level)
//   busy       out  1          measurement in progress (FLUSH/ACCUM/DRAIN)
//   max_err    out  DATA_W+1   largest |diff| in window (macro only)
//
// Timing:
//   data_valid rises SKIP + 2^LOG2_SAMPLES + 3 rising edges after the edge
//   that accepted start. ACCUM lasts 2^LOG2_SAMPLES capture cycles plus one
//   cycle in which the sample counter sits at its terminal count. DRAIN then
//   lets the square and accumulate stages empty before the result is loaded.
//   LOG2_SAMPLES must be at least 1.
// -----------------------------------------------------------------------------
module err_accumulator #(
  parameter int DATA_W       = 29,
  parameter int ACC_W        = 64,
  parameter int LOG2_SAMPLES = 16,
  parameter int SKIP         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_ref,
  output logic [ACC_W-1:0]  data_out,
  output logic              data_valid,
  output logic              busy
`ifdef ERR_ACCUMULATOR_MAX_ERR_EN
  ,
  output logic [DATA_W:0]   max_err
`endif
);

  localparam int DIFF_W = DATA_W + 1;
  localparam int SQ_W   = 2 * DIFF_W;
  // One guard bit above the wider of accumulator and square, so that
  // overflow of the add is always visible.
  localparam int SUM_W  = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;
  localparam int CNT_W  = LOG2_SAMPLES + 1;
  localparam int FL_W   = (SKIP > 1) ? $clog2(SKIP) : 1;

  localparam logic [CNT_W-1:0] SAMPLES_TC  = {1'b1, {LOG2_SAMPLES{1'b0}}};
  localparam logic [FL_W-1:0]  FLUSH_LAST  = FL_W'((SKIP > 0) ? (SKIP - 1) : 0);
  localparam logic [ACC_W-1:0] ACC_MAX     = {ACC_W{1'b1}};
  localparam logic [SUM_W-1:0] ACC_MAX_SUM = {{(SUM_W - ACC_W){1'b0}}, {ACC_W{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_ACCUM = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Control state
  state_t             state_q, state_d;
  logic [FL_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]   smp_cnt_q, smp_cnt_d;
  logic               drain_cnt_q, drain_cnt_d;
  logic               accept_s;
  logic               capture_s;
  logic               load_s;

  // Datapath
  logic [DIFF_W-1:0]  diff_q, diff_d;
  logic               s1_vld_q, s1_vld_d;
  logic [SQ_W-1:0]    sq_ext_s;
  logic [SQ_W-1:0]    sq_q, sq_d;
  logic               s2_vld_q, s2_vld_d;
  logic [SUM_W-1:0]   sum_s;
  logic [ACC_W-1:0]   acc_q, acc_d;

  // Registered outputs
  logic [ACC_W-1:0]   data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic               busy_q, busy_d;

`ifdef ERR_ACCUMULATOR_MAX_ERR_EN
  logic [DIFF_W-1:0]  abs_q, abs_d;
  logic [DIFF_W-1:0]  max_q, max_d;
`endif

  // FSM next-state, counters and control strobes
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    smp_cnt_d   = smp_cnt_q;
    drain_cnt_d = drain_cnt_q;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    load_s      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept_s    = 1'b1;
          flush_cnt_d = {FL_W{1'b0}};
          smp_cnt_d   = {CNT_W{1'b0}};
          drain_cnt_d = 1'b0;
          if (SKIP == 0) begin
            state_d = S_ACCUM;
          end else begin
            state_d = S_FLUSH;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d = S_ACCUM;
        end else begin
          flush_cnt_d = flush_cnt_q + {{(FL_W - 1){1'b0}}, 1'b1};
        end
      end
      S_ACCUM: begin
        // The counter is one bit wider than needed for the sample index so
        // the terminal count is a distinct value instead of a wrap to 0.
        if (smp_cnt_q == SAMPLES_TC) begin
          state_d = S_DRAIN;
        end else begin
          capture_s = 1'b1;
          smp_cnt_d = smp_cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q) begin
          state_d = S_DONE;
          load_s  = 1'b1;
        end else begin
          drain_cnt_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath next-state: difference, square, saturating accumulate
  always_comb begin
    diff_d   = diff_q;
    s1_vld_d = capture_s;
    s2_vld_d = s1_vld_q;
    if (capture_s) begin
      diff_d = {data_in[DATA_W-1], data_in} - {data_ref[DATA_W-1], data_ref};
    end else begin
      diff_d = diff_q;
    end

    // Signed square in full width; the result is never negative, so the
    // bit pattern is directly the unsigned square.
    sq_ext_s = {{DIFF_W{diff_q[DIFF_W-1]}}, diff_q};
    sq_d     = $unsigned($signed(sq_ext_s) * $signed(sq_ext_s));

    sum_s = {{(SUM_W - ACC_W){1'b0}}, acc_q} + {{(SUM_W - SQ_W){1'b0}}, sq_q};
    if (accept_s) begin
      acc_d = {ACC_W{1'b0}};
    end else if (s2_vld_q) begin
      // Once at the maximum, every further add also exceeds it, so the
      // accumulator holds there for the rest of the window.
      if (sum_s > ACC_MAX_SUM) begin
        acc_d = ACC_MAX;
      end else begin
        acc_d = sum_s[ACC_W-1:0];
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Output register next-state, aligned with the FSM state being entered
  always_comb begin
    busy_d       = (state_d == S_FLUSH) || (state_d == S_ACCUM) || (state_d == S_DRAIN);
    data_valid_d = (state_d == S_DONE);
    if (load_s) begin
      data_out_d = acc_q >> LOG2_SAMPLES;
    end else begin
      data_out_d = data_out_q;
    end
  end

`ifdef ERR_ACCUMULATOR_MAX_ERR_EN
  // Magnitude of the S1 difference and running maximum over the window
  always_comb begin
    // Negating -2^DATA_W wraps to the same bit pattern, which read as
    // unsigned is exactly 2^DATA_W.
    if (diff_q[DIFF_W-1]) begin
      abs_d = -diff_q;
    end else begin
      abs_d = diff_q;
    end
    if (accept_s) begin
      max_d = {DIFF_W{1'b0}};
    end else if (s2_vld_q && (abs_q > max_q)) begin
      max_d = abs_q;
    end else begin
      max_d = max_q;
    end
  end

  // Maximum-error pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abs_q <= {DIFF_W{1'b0}};
      max_q <= {DIFF_W{1'b0}};
    end else begin
      abs_q <= abs_d;
      max_q <= max_d;
    end
  end

  assign max_err = max_q;
`endif

  // FSM state and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= {FL_W{1'b0}};
      smp_cnt_q   <= {CNT_W{1'b0}};
      drain_cnt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      smp_cnt_q   <= smp_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Datapath pipeline registers (S1 diff, S2 square, S3 accumulator)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q   <= {DIFF_W{1'b0}};
      s1_vld_q <= 1'b0;
      sq_q     <= {SQ_W{1'b0}};
      s2_vld_q <= 1'b0;
      acc_q    <= {ACC_W{1'b0}};
    end else begin
      diff_q   <= diff_d;
      s1_vld_q <= s1_vld_d;
      sq_q     <= sq_d;
      s2_vld_q <= s2_vld_d;
      acc_q    <= acc_d;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q   <= {ACC_W{1'b0}};
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_err_accumulator.sv
// -----------------------------------------------------------------------------
// tb_err_accumulator
//
// Directed testbench. Three instances of err_accumulator share the clock,
// reset and sample buses, and each has its own start input:
//   a: ACC_W=64, LOG2_SAMPLES=4, SKIP=2  (constant-error, restart, reset)
//   b: ACC_W=64, LOG2_SAMPLES=2, SKIP=0  (per-sample window with garbage)
//   c: ACC_W=40, LOG2_SAMPLES=4, SKIP=2  (saturation)
// Only one instance is started at a time; idle instances ignore the buses.
// -----------------------------------------------------------------------------
module tb_err_accumulator;

  logic        clk;
  logic        rst;
  logic        start_a, start_b, start_c;
  logic [28:0] din, dref;

  logic [63:0] data_out_a, data_out_b;
  logic [39:0] data_out_c;
  logic        valid_a, valid_b, valid_c;
  logic        busy_a, busy_b, busy_c;
`ifdef ERR_ACCUMULATOR_MAX_ERR_EN
  logic [29:0] max_err_a, max_err_b, max_err_c;
`endif

  int n_checks;
  int n_errors;
  int lat;

  err_accumulator #(.DATA_W(29), .ACC_W(64), .LOG2_SAMPLES(4), .SKIP(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .data_in(din), .data_ref(dref),
    .data_out(data_out_a), .data_valid(valid_a), .busy(busy_a)
`ifdef ERR_ACCUMULATOR_MAX_ERR_EN
    , .max_err(max_err_a)
`endif
  );

  err_accumulator #(.DATA_W(29), .ACC_W(64), .LOG2_SAMPLES(2), .SKIP(0)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .data_in(din), .data_ref(dref),
    .data_out(data_out_b), .data_valid(valid_b), .busy(busy_b)
`ifdef ERR_ACCUMULATOR_MAX_ERR_EN
    , .max_err(max_err_b)
`endif
  );

  err_accumulator #(.DATA_W(29), .ACC_W(40), .LOG2_SAMPLES(4), .SKIP(2)) u_dut_c (
    .clk(clk), .rst(rst), .start(start_c), .data_in(din), .data_ref(dref),
    .data_out(data_out_c), .data_valid(valid_c), .busy(busy_c)
`ifdef ERR_ACCUMULATOR_MAX_ERR_EN
    , .max_err(max_err_c)
`endif
  );

  // Free-running clock, 10 time units
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic valid_of(input int sel);
    case (sel)
      0:       return valid_a;
      1:       return valid_b;
      default: return valid_c;
    endcase
  endfunction

  // Drive start for one cycle; returns #1 after the accepting edge (E0)
  task automatic pulse_start(input int sel);
    @(negedge clk);
    case (sel)
      0:       start_a = 1'b1;
      1:       start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  // Count rising edges until data_valid is seen, bounded
  task automatic wait_valid(input int sel, output int edges);
    edges = 0;
    while (!valid_of(sel) && (edges < 200)) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    start_a  = 1'b0;
    start_b  = 1'b0;
    start_c  = 1'b0;
    din      = 29'd0;
    dref     = 29'd0;
    step(3);
    @(negedge clk);
    rst = 1'b0;
    step(1);

    // Reset state
    check_val("rst_out_a", data_out_a, 64'd0);
    check_val("rst_valid_a", {63'd0, valid_a}, 64'd0);
    check_val("rst_busy_a", {63'd0, busy_a}, 64'd0);
    check_val("rst_valid_b", {63'd0, valid_b}, 64'd0);
    check_val("rst_out_c", {24'd0, data_out_c}, 64'd0);

    // Equal inputs: zero error, full latency 2+16+3
    din  = 29'd12345;
    dref = 29'd12345;
    pulse_start(0);
    check_val("busy_after_start", {63'd0, busy_a}, 64'd1);
    wait_valid(0, lat);
    check_val("lat_equal", 64'(lat), 64'd21);
    check_val("mse_equal", data_out_a, 64'd0);
    check_val("busy_done", {63'd0, busy_a}, 64'd0);

    // +3 error, restarted from DONE: valid drops on the accepting edge
    din  = 29'd12348;
    pulse_start(0);
    check_val("valid_drop_restart", {63'd0, valid_a}, 64'd0);
    wait_valid(0, lat);
    check_val("lat_plus3", 64'(lat), 64'd21);
    check_val("mse_plus3", data_out_a, 64'd9);
`ifdef ERR_ACCUMULATOR_MAX_ERR_EN
    check_val("maxerr_plus3", {34'd0, max_err_a}, 64'd3);
`endif

    // -3 error
    din = 29'd12342;
    pulse_start(0);
    wait_valid(0, lat);
    check_val("mse_minus3", data_out_a, 64'd9);
`ifdef ERR_ACCUMULATOR_MAX_ERR_EN
    check_val("maxerr_minus3", {34'd0, max_err_a}, 64'd3);
`endif

    // SKIP=0 window of 4: diffs 1,2,3,4, garbage 100 outside the window
    dref = 29'd1000;
    din  = 29'd1100;
    pulse_start(1);
    din = 29'd1001;
    step(1);
    din = 29'd1002;
    step(1);
    din = 29'd1003;
    step(1);
    din = 29'd1004;
    step(1);
    din = 29'd1100;
    wait_valid(1, lat);
    check_val("lat_window", 64'(4 + lat), 64'd7);
    check_val("mse_window", data_out_b, 64'd7);
`ifdef ERR_ACCUMULATOR_MAX_ERR_EN
    check_val("maxerr_window", {34'd0, max_err_b}, 64'd4);
`endif

    // Saturation on the 40-bit accumulator: diff = 2^29-1
    din  = 29'h0FFF_FFFF;
    dref = 29'h1000_0000;
    pulse_start(2);
    wait_valid(2, lat);
    check_val("lat_sat", 64'(lat), 64'd21);
    check_val("mse_sat", {24'd0, data_out_c}, 64'h0000_000F_FFFF_FFFF);
`ifdef ERR_ACCUMULATOR_MAX_ERR_EN
    check_val("maxerr_sat", {34'd0, max_err_c}, 64'h0000_0000_1FFF_FFFF);
`endif

    // Second start during ACCUM is ignored; timing counted from first start
    din  = 29'd105;
    dref = 29'd100;
    pulse_start(0);
    step(9);
    pulse_start(0);
    check_val("busy_ignored_start", {63'd0, busy_a}, 64'd1);
    wait_valid(0, lat);
    check_val("lat_ignored_start", 64'(10 + lat), 64'd21);
    check_val("mse_ignored_start", data_out_a, 64'd25);

    // Reset mid-ACCUM clears outputs at once; fresh run has no residue
    din = 29'd107;
    pulse_start(0);
    step(8);
    rst = 1'b1;
    #1;
    check_val("midrst_out", data_out_a, 64'd0);
    check_val("midrst_valid", {63'd0, valid_a}, 64'd0);
    check_val("midrst_busy", {63'd0, busy_a}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    din = 29'd98;
    pulse_start(0);
    wait_valid(0, lat);
    check_val("lat_after_rst", 64'(lat), 64'd21);
    check_val("mse_after_rst", data_out_a, 64'd4);
`ifdef ERR_ACCUMULATOR_MAX_ERR_EN
    check_val("maxerr_after_rst", {34'd0, max_err_a}, 64'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
